// File: rtl/vpu_pkg.sv
// Purpose : shared types, pathway encodings and fixed-point helpers for vpu_pipe.
// Latency : n/a (package only).
// Backpressure: n/a. VPU_PIPE_SAT_EN selects saturating (defined) or wrapping (undefined) reduction.
package vpu_pkg;

    // Widest supported DATA_W; intermediates are held wide enough that no
    // DATA_W+1 sum or 2*DATA_W product can overflow before reduction.
    localparam int MAX_W = 32;
    localparam int PW    = 2 * MAX_W + 2;

    typedef logic signed [MAX_W-1:0] word_t;
    typedef logic signed [PW-1:0]    wide_t;

    // Bit positions inside the 4-bit pathway tag {bias, lr, loss, lrd}.
    localparam int P_LRD  = 0;
    localparam int P_LOSS = 1;
    localparam int P_LR   = 2;
    localparam int P_BIAS = 3;

    localparam logic [3:0] PATH_NONE  = 4'b0000;
    localparam logic [3:0] PATH_FWD   = 4'b1100;
    localparam logic [3:0] PATH_TRANS = 4'b1111;
    localparam logic [3:0] PATH_BWD   = 4'b0001;

    // One lane's view of a beat between stages. Words are always the sign
    // extension of a DATA_W value.
    typedef struct packed {
        logic [3:0] pathway;
        logic       lane_valid;
        word_t      data;
        word_t      y;
        word_t      h;
    } beat_t;

    // Full-precision product, arithmetic shift right (rounds toward -inf).
    function automatic wide_t fx_mul_shift(input wide_t a, input wide_t b, input int frac_w);
        return (a * b) >>> frac_w;
    endfunction

    // Bring a wide intermediate back to a data_w-bit value (sign-extended to word_t).
    function automatic word_t fx_reduce(input wide_t v, input int data_w);
`ifdef VPU_PIPE_SAT_EN
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (data_w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi)
            return word_t'(hi);
        else if (v < lo)
            return word_t'(lo);
        else
            return word_t'(v);
`else
        return word_t'((v <<< (PW - data_w)) >>> (PW - data_w));
`endif
    endfunction

endpackage

// File: rtl/vpu_pipe_if.sv
// Purpose : beat handshake bundle between the systolic array side and vpu_pipe.
// Latency : n/a (wiring only).
// Backpressure: in_ready/out_ready; master = producer/consumer side, slave = vpu_pipe.
interface vpu_pipe_if #(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic [3:0]                       in_pathway;
    logic [N_LANES-1:0]               in_lane_valid;
    logic [N_LANES-1:0][DATA_W-1:0]   in_data;
    logic [N_LANES-1:0][DATA_W-1:0]   in_bias;
    logic [N_LANES-1:0][DATA_W-1:0]   in_y;
    logic [N_LANES-1:0][DATA_W-1:0]   in_h;
    logic [DATA_W-1:0]                leak_factor;
    logic [DATA_W-1:0]                inv_2n;
    logic                             out_valid;
    logic                             out_ready;
    logic [N_LANES-1:0]               out_lane_valid;
    logic [N_LANES-1:0][DATA_W-1:0]   out_data;
    logic                             idle;

    modport master (
        output in_valid, in_pathway, in_lane_valid, in_data, in_bias, in_y, in_h,
               leak_factor, inv_2n, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_data, idle
    );

    modport slave (
        input  in_valid, in_pathway, in_lane_valid, in_data, in_bias, in_y, in_h,
               leak_factor, inv_2n, out_ready,
        output in_ready, out_valid, out_lane_valid, out_data, idle
    );
endinterface

// File: rtl/vpu_pipe_lane.sv
// Purpose : one lane's 4-stage datapath (bias, leaky ReLU, loss, leaky ReLU derivative).
// Latency : 4 registered stages; all advance together on adv.
// Backpressure: every register holds while adv = 0. Ports: per-beat operands in, lane result out.
module vpu_pipe_lane
    import vpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic [3:0]        in_pathway,
    input  logic              in_lane_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_bias,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_h,
    input  logic [DATA_W-1:0] leak_factor,
    input  logic [DATA_W-1:0] inv_2n,
    output logic              out_lane_valid,
    output logic [DATA_W-1:0] out_data
);

    function automatic word_t sx(input logic [DATA_W-1:0] v);
        return word_t'(signed'(v));
    endfunction

    beat_t s1_q, s2_q, s3_q;
    beat_t s1_d, s2_d, s3_d;
    word_t s3_hc_q;     // S2 output h, riding alongside the beat into S3
    word_t s4_q, s4_d;
    logic  s4_lv_q;
    word_t hsel;
    word_t leak, inv;

    assign leak = sx(leak_factor);
    assign inv  = sx(inv_2n);

    always_comb begin
        s1_d            = '0;
        s1_d.pathway    = in_pathway;
        s1_d.lane_valid = in_lane_valid;
        s1_d.y          = sx(in_y);
        s1_d.h          = sx(in_h);
        s1_d.data       = sx(in_data);
        if (in_pathway[P_BIAS])
            s1_d.data = fx_reduce(wide_t'(sx(in_data)) + wide_t'(sx(in_bias)), DATA_W);

        s2_d = s1_q;
        if (s1_q.pathway[P_LR] && s1_q.data < 0)
            s2_d.data = fx_reduce(fx_mul_shift(wide_t'(s1_q.data), wide_t'(leak), FRAC_W), DATA_W);

        s3_d = s2_q;
        if (s2_q.pathway[P_LOSS])
            s3_d.data = fx_reduce(fx_mul_shift(wide_t'(s2_q.data) - wide_t'(s2_q.y),
                                               wide_t'(inv), FRAC_W), DATA_W);

        // Transition beats differentiate against their own activation; pure
        // backward beats bring the cached H in with the operands.
        hsel = s3_q.pathway[P_LOSS] ? s3_hc_q : s3_q.h;
        s4_d = s3_q.data;
        if (s3_q.pathway[P_LRD] && hsel < 0)
            s4_d = fx_reduce(fx_mul_shift(wide_t'(s3_q.data), wide_t'(leak), FRAC_W), DATA_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            s3_hc_q <= '0;
            s4_q    <= '0;
            s4_lv_q <= 1'b0;
        end else if (adv) begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            s3_hc_q <= s2_q.data;
            s4_q    <= s4_d;
            s4_lv_q <= s3_q.lane_valid;
        end
    end

    assign out_lane_valid = s4_lv_q;
    assign out_data       = s4_lv_q ? s4_q[DATA_W-1:0] : '0;

    // S3 fields that S4 never consumes, and the sign-extension bits of S4.
    logic unused_bits;
    assign unused_bits = ^{s3_q.y, s3_q.pathway[3:2], s4_q};

endmodule

// File: rtl/vpu_pipe.sv
// Purpose : N_LANES-wide pipelined VPU (bias -> leaky ReLU -> loss -> leaky ReLU derivative).
// Latency : 4 cycles accept-to-out_valid, 1 beat/cycle; ports clk, rst, bus (vpu_pipe_if.slave).
// Backpressure: whole pipe holds when out_valid && !out_ready; in_ready = out_ready || !out_valid.
// Build option VPU_PIPE_SAT_EN: saturate stage results instead of wrapping.
module vpu_pipe
    import vpu_pkg::*;
#(
    parameter int N_LANES = 2,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8
) (
    input  logic       clk,
    input  logic       rst,
    vpu_pipe_if.slave  bus
);

    logic [3:0] vld_q;      // vld_q[k] = stage k+1 holds a beat
    logic [2:0] cnt_q;      // beats in flight, 0..4
    logic       adv;
    logic       acc;
    logic       out_hs;

    assign adv           = bus.out_ready || !vld_q[3];
    assign acc           = bus.in_valid && adv;
    assign out_hs        = vld_q[3] && bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[3];
    assign bus.idle      = (cnt_q == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            if (adv)
                vld_q <= {vld_q[2:0], acc};
            case ({acc, out_hs})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        // Bubbles enter with lane_valid = 0 so they surface as zero data.
        vpu_pipe_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk            (clk),
            .rst            (rst),
            .adv            (adv),
            .in_pathway     (bus.in_pathway),
            .in_lane_valid  (bus.in_lane_valid[i] & bus.in_valid),
            .in_data        (bus.in_data[i]),
            .in_bias        (bus.in_bias[i]),
            .in_y           (bus.in_y[i]),
            .in_h           (bus.in_h[i]),
            .leak_factor    (bus.leak_factor),
            .inv_2n         (bus.inv_2n),
            .out_lane_valid (bus.out_lane_valid[i]),
            .out_data       (bus.out_data[i])
        );
    end

endmodule

// File: doc/vpu_pipe.md
# vpu_pipe

Parametrised, pipelined vector processing unit between the systolic array outputs and the unified buffer. It generalises the 2-lane VPU to `N_LANES` lanes and configurable fixed-point width. Every stage is registered, and each beat carries its own pathway tag, so the mode can change on any beat. It adds ready/valid backpressure, and aligns the cached H matrix for the transition pathway through the pipeline.

## Interface
Parameters:
- `N_LANES`, 2, number of parallel lanes (≥1).
- `DATA_W`, 16, signed fixed-point word width.
- `FRAC_W`, 8, fractional bits (Q(DATA_W−FRAC_W).FRAC_W).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_pathway` in 4: {bias, lr, loss, lrd} enables for this beat.
- `in_lane_valid` in N_LANES: per-lane valid for this beat.
- `in_data` in N_LANES×DATA_W: systolic array outputs.
- `in_bias` in N_LANES×DATA_W: bias scalars.
- `in_y` in N_LANES×DATA_W: targets Y.
- `in_h` in N_LANES×DATA_W: H for backward pathway.
- `leak_factor` in DATA_W: leaky ReLU slope, quasi-static.
- `inv_2n` in DATA_W: 2/batch_size, quasi-static.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts output beat.
- `out_lane_valid` out N_LANES: per-lane valid of the output beat.
- `out_data` out N_LANES×DATA_W: results.
- `idle` out 1: no beat in flight.

## Operation
- Four register stages, always traversed: S1 bias, S2 lr, S3 loss, S4 lrd. A disabled stage registers its input unchanged.
- Each beat carries its pathway, lane valids, and its Y/H operands down the pipe. `leak_factor` and `inv_2n` are read live and must be stable while `idle` = 0.
- Bias: z = x + b.
- Lr: h = x ≥ 0 ? x : (x·leak) >>> FRAC_W.
- Loss: g = ((h − y)·inv_2n) >>> FRAC_W.
- Lrd: out = hsel ≥ 0 ? g : (g·leak) >>> FRAC_W.
- hsel selection for lrd:
  - Pathway bit1 = 1: hsel is the S2 output h of the same beat, carried one stage to S4 (H cache aligned with loss).
  - Pathway bit1 = 0: hsel is the beat's `in_h`.
- Products are computed at 2·DATA_W, then arithmetic shifted right (truncation toward −∞). Add/sub are computed at DATA_W+1. Every stage result is then reduced to DATA_W (see Configuration).
- Legal pathways: 0000 passthrough, 1100 forward, 1111 transition, 0001 backward. Any other code is executed literally per its bits; no error is raised.
- Lanes with lane-valid = 0 are still computed, but their `out_data` is forced to 0.

## Timing
- Latency: fixed 4 cycles from accept to `out_valid`, when not stalled.
- Stall: the pipe advances when `adv` = `out_ready || !out_valid`. `in_ready` = `adv`. While stalled, all stage registers hold.
- Throughput: one beat per cycle with `out_ready` = 1.
- Ordering: beats leave in accept order. None are dropped or duplicated.
- A 3-bit occupancy counter tracks beats in flight:
  - +1 on accept, −1 on output handshake, unchanged when both occur in the same cycle.
  - Range 0..4.
  - `idle` = (count == 0).
- Reset (any time, including mid-stream):
  - All stage valids and the counter clear; in-flight beats are discarded.
  - Outputs: `out_valid` = 0, `out_lane_valid` = 0, `out_data` = 0, `in_ready` = 1, `idle` = 1.
- An `in_pathway` change between consecutive beats needs no bubble.

## Configuration
- `VPU_PIPE_SAT_EN` defined: every stage result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Undefined: results wrap (two's-complement truncation to DATA_W).

## Structure
- Package `vpu_pkg` holds:
  - pathway bit indices;
  - constants `PATH_NONE`, `PATH_FWD`, `PATH_TRANS`, `PATH_BWD`;
  - stage-beat struct typedef {pathway, lane_valid, data, y, h};
  - function `fx_mul_shift` for the fixed-point multiply-and-shift;
  - function `fx_reduce` for saturate/wrap reduction.
- Sub-module `vpu_pipe_lane`: one lane's 4-stage datapath with a shared advance enable, generated `N_LANES` times. Control (valid chain, counter, handshake) lives in the top.

## Test plan
All values Q8.8, `leak_factor` = 0x0080.
- Forward 1100: x = 0xFF00, b = 0x0080 → `out_data` = 0xFFC0 exactly 4 cycles after accept.
- Transition 1111: x = 0x0100, b = 0, y = 0x0080, `inv_2n` = 0x0100 → 0x0080. Same with x = 0xFE00 (h = 0xFF00): loss = 0xFE80, out = 0xFF40.
- Backward 0001: x = 0x0200, h = 0xFF00 → 0x0100. Mixed 1100/0001/1111 on back-to-back beats → each result matches its own pathway.
- Saturation 1000: x = 0x7F00, b = 0x7F00 → 0x7FFF with `VPU_PIPE_SAT_EN`, 0xFE00 without.
- Backpressure: 6 beats streamed, `out_ready` low for 3 cycles after the first output → `in_ready` low during the stall, all 6 outputs delivered in order, `idle` = 1 after the last.
- Reset asserted with 3 beats in flight → next cycle `out_valid` = 0, `idle` = 1, `in_ready` = 1. The next accepted beat emerges after 4 cycles.
